iq_mixer_dec: RTL
=================

# iq_mixer_dec

Parametrised fs/4 quadrature mixer with integrate-and-dump decimation. It sits between the ADC sample interface and the baseband despreading path. The block generates its own 4-phase LO internally, so no separate sine/cosine FSM is needed. It mixes each accepted I/Q IF sample down to baseband, supports upper/lower sideband selection, sums DEC consecutive mixed samples, and emits one registered result per frame with a valid pulse.

## Interface
- IN_W, 7, signed width of i_if/q_if (≥2)
- DEC, 4, decimation factor, number of mixed samples summed per output (≥1, power of 2)
- OUT_W (localparam), IN_W+2+$clog2(DEC), signed output width (11 at defaults)

- clk  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  i_if/q_if hold a new sample this cycle (one-cycle strobe, no backpressure)
- i_if  in  IN_W  signed I IF sample
- q_if  in  IN_W  signed Q IF sample
- conj  in  1  0: LO = cos + j·sin; 1: LO sine negated (opposite sideband)
- phase_clr  in  1  resync: LO phase, frame counter, accumulators to start
- i_bb  out  OUT_W  signed decimated baseband I, held between dumps
- q_bb  out  OUT_W  signed decimated baseband Q, held between dumps
- out_valid  out  1  one-cycle pulse, i_bb/q_bb updated this cycle
- lo_phase  out  2  current LO phase (debug)

## Operation
- LO phase counter p (2 bits) advances by 1 mod 4 on each accepted sample.
  - p=0: cos=+1, sin=0
  - p=1: cos=0, sin=+1
  - p=2: cos=−1, sin=0
  - p=3: cos=0, sin=−1
  - If conj_f=1, sin is negated.
- Mixing, stage 1, registered:
  - I_mix = I·cos − Q·sin
  - Q_mix = I·sin + Q·cos
  - Result width is IN_W+1 signed, so −(−2^(IN_W−1)) is representable. No saturation anywhere.
- Frame counter k runs 0..DEC−1 and advances on each stage-1 valid.
- conj_f is captured from conj on the accepted sample that starts a frame, i.e. the one that will land at k=0. It is held for the whole frame, so toggling conj mid-frame has no effect until the next frame.
- Accumulate, stage 2:
  - At k=0, acc loads the sign-extended mix.
  - Otherwise acc accumulates acc+mix.
  - At k=DEC−1, i_bb/q_bb load acc+mix (or mix alone when DEC=1), out_valid pulses, and k wraps to 0.
- Overflow-free by width: |sum| ≤ DEC·2^(IN_W−1) < 2^(OUT_W−1).
- phase_clr=1:
  - Clears p, k, acc and the stage-1 valid.
  - out_valid is forced 0 that cycle; i_bb/q_bb hold.
  - If in_valid is high in the same cycle, that sample is accepted as p=0, frame start. The loaded sample wins over the clear in stage 1.
- reset (sync) has priority over everything:
  - Clears p, k, acc, conj_f and all valids.
  - i_bb=q_bb=0, out_valid=0, lo_phase=0.

## Timing
- Sample with in_valid high in cycle n: stage-1 result in cycle n+1.
- If it is the DEC-th sample of a frame, out_valid is high in cycle n+2 with i_bb/q_bb valid in the same cycle.
- Fixed pipeline latency is 2 cycles from the last sample of a frame to out_valid.
- in_valid may be high every cycle (full rate) or sparse; gaps do not advance p or k.
- out_valid is never high on two consecutive cycles unless DEC=1 and in_valid is continuous.
- lo_phase shows the phase that the next accepted sample will use.
- Reset asserted mid-frame:
  - The partial frame is discarded, and no out_valid occurs for it.
  - After deassertion, the first accepted sample is p=0, k=0.
- Reset values: i_bb=0, q_bb=0, out_valid=0, lo_phase=0.

## Test plan
- DEC=1, conj=0, I=10, Q=0 on 4 consecutive cycles -> i_bb = 10,0,−10,0; q_bb = 0,10,0,−10, out_valid on each of 4 cycles starting 2 cycles after the first sample.
- DEC=4, conj=0, (I,Q) = (10,0),(0,−10),(−10,0),(0,10) -> single out_valid 2 cycles after the last sample, i_bb=40, q_bb=0. Repeat with conj=1 set before the frame -> i_bb=0, q_bb=0.
- DEC=1, I=−64, Q=0 presented at p=2 -> i_bb=+64 (no wrap), q_bb=0. At p=3 with Q=−64 -> i_bb=−64, q_bb=0.
- DEC=4, sparse in_valid (1 of 3 cycles) with the same frame as scenario 2 -> identical result, and lo_phase steps only on accepted samples.
- DEC=4, phase_clr after 2 samples, together with a new sample -> the 2 old samples are discarded, the new sample takes p=0, and out_valid follows 3 further samples; conj toggled mid-frame -> ignored until the next frame.
- reset pulse after 3 of 4 samples -> no out_valid, i_bb=q_bb=0, lo_phase=0. The next 4 samples produce the expected frame sum.

Source files
------------

// File: rtl/iq_mixer_dec.sv
// fs/4 quadrature mixer with integrate-and-dump decimation.
// Stage 0 tracks LO phase/frame position, stage 1 registers the mix, stage 2 accumulates and dumps.
module iq_mixer_dec #(
    parameter  int IN_W  = 7,
    parameter  int DEC   = 4,
    localparam int OUT_W = IN_W + 2 + $clog2(DEC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  i_if,
    input  logic signed [IN_W-1:0]  q_if,
    input  logic                    conj,
    input  logic                    phase_clr,
    output logic signed [OUT_W-1:0] i_bb,
    output logic signed [OUT_W-1:0] q_bb,
    output logic                    out_valid,
    output logic [1:0]              lo_phase
);

    localparam int MW = IN_W + 1;
    localparam int KW = (DEC > 1) ? $clog2(DEC) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DEC - 1);

    logic [1:0]           p;
    logic [KW-1:0]        f_cnt;
    logic                 conj_f;
    logic [1:0]           p_use;
    logic                 frame_start;
    logic                 conj_eff;
    logic signed [MW-1:0] i_ext;
    logic signed [MW-1:0] q_ext;
    logic signed [MW-1:0] mix_i_d;
    logic signed [MW-1:0] mix_q_d;

    logic                 s1_valid;
    logic signed [MW-1:0] mix_i;
    logic signed [MW-1:0] mix_q;

    logic [KW-1:0]           k;
    logic signed [OUT_W-1:0] acc_i;
    logic signed [OUT_W-1:0] acc_q;
    logic signed [OUT_W-1:0] mix_i_x;
    logic signed [OUT_W-1:0] mix_q_x;
    logic signed [OUT_W-1:0] sum_i;
    logic signed [OUT_W-1:0] sum_q;

    // A phase_clr with a coincident sample restarts the frame on that very sample.
    always_comb begin
        p_use       = phase_clr ? 2'd0 : p;
        frame_start = phase_clr || (f_cnt == '0);
        conj_eff    = frame_start ? conj : conj_f;
        i_ext       = {i_if[IN_W-1], i_if};
        q_ext       = {q_if[IN_W-1], q_if};
        mix_i_d     = i_ext;
        mix_q_d     = q_ext;
        case (p_use)
            2'd0: begin
                mix_i_d = i_ext;
                mix_q_d = q_ext;
            end
            2'd2: begin
                mix_i_d = -i_ext;
                mix_q_d = -q_ext;
            end
            default: begin
                // Odd phases: effective sin is +1 for p=1, -1 for p=3, flipped by conj.
                if ((p_use == 2'd1) != conj_eff) begin
                    mix_i_d = -q_ext;
                    mix_q_d = i_ext;
                end else begin
                    mix_i_d = q_ext;
                    mix_q_d = -i_ext;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p      <= 2'd0;
            f_cnt  <= '0;
            conj_f <= 1'b0;
        end else if (in_valid) begin
            p <= p_use + 2'd1;
            if (DEC == 1)
                f_cnt <= '0;
            else
                f_cnt <= (phase_clr ? KW'(0) : f_cnt) + KW'(1);
            if (frame_start)
                conj_f <= conj;
        end else if (phase_clr) begin
            p     <= 2'd0;
            f_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            mix_i    <= '0;
            mix_q    <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                mix_i <= mix_i_d;
                mix_q <= mix_q_d;
            end
        end
    end

    always_comb begin
        mix_i_x = {{(OUT_W-MW){mix_i[MW-1]}}, mix_i};
        mix_q_x = {{(OUT_W-MW){mix_q[MW-1]}}, mix_q};
        sum_i   = (k == '0) ? mix_i_x : acc_i + mix_i_x;
        sum_q   = (k == '0) ? mix_q_x : acc_q + mix_q_x;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k         <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            i_bb      <= '0;
            q_bb      <= '0;
            out_valid <= 1'b0;
        end else if (phase_clr) begin
            k         <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (s1_valid) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                if (k == K_LAST) begin
                    i_bb      <= sum_i;
                    q_bb      <= sum_q;
                    out_valid <= 1'b1;
                    k         <= '0;
                end else begin
                    k <= k + KW'(1);
                end
            end
        end
    end

    assign lo_phase = p;

endmodule
